uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered 8N1 UART transmitter with a programmable bit period and a small byte FIFO. It accepts bytes from on-chip logic through a write_enable/ready handshake and serialises them LSB-first on UART_TX at CLKS_PER_BIT clocks per bit. It is the transmit end of the board serial link and is paired with the UART receiver on the same clock domain.

## Interface
- CLKS_PER_BIT, 104: clocks per serial bit (12 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 2: FIFO holds 2**FIFO_DEPTH_LOG2 bytes (default 4).
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to enqueue.
- write_enable  in  1  enqueue request; data_in is accepted on a rising edge where write_enable=1 and ready=1.
- ready  out  1  FIFO not full; combinational from registered count.
- UART_TX  out  1  serial line, idle high; registered.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_count  out  FIFO_DEPTH_LOG2+1  bytes currently queued, not counting the byte being shifted.
- overflow  out  1  sticky; set when write_enable=1 while ready=0; cleared only by reset.

## Operation
- Reset values: UART_TX=1, ready=1, busy=0, fifo_count=0, overflow=0, FSM in IDLE, bit timer=0, FIFO pointers=0.
- FIFO: circular buffer, separate read/write pointers wrapping modulo depth. Write accepted only when ready=1. A write while full is dropped and sets overflow. Simultaneous accepted write and pop leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TX=1. If fifo_count≠0, pop the head into shift register, clear timer, go START.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: UART_TX=shift[index] for CLKS_PER_BIT cycles per bit, index 0..7 (LSB first); after bit 7 go STOP.
  - STOP: UART_TX=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle: if fifo_count≠0, pop and go directly to START (no idle gap); else go IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1; a bit advances on the cycle the timer is at CLKS_PER_BIT-1. The timer is wide enough for 2*CLKS_PER_BIT-1 so the STOP duration fits.
- Contents of a popped byte are frozen in the shift register. Later FIFO writes do not affect the frame in flight.
- Reset mid-frame: the line returns high asynchronously. The frame is truncated, the FIFO is emptied and overflow is cleared.

## Timing
- Latency: write_enable sampled at edge k into an empty FIFO while IDLE → fifo_count=1 after edge k, pop at edge k+1, UART_TX=0 after edge k+1 (start bit begins one cycle after acceptance).
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles: 10*CLKS_PER_BIT for STOP_BITS=1, 11*CLKS_PER_BIT for STOP_BITS=2.
- Back-to-back: with data queued, the next start bit immediately follows the last stop-bit cycle. Frames are contiguous.
- ready drops in the cycle after the write that fills the FIFO. It rises in the cycle after the pop that frees a slot.
- busy falls in the cycle UART_TX re-enters IDLE with an empty FIFO.

## Test plan
- CLKS_PER_BIT=4, write 0x55 once → UART_TX sequence, 4 cycles each: 0 (start), 1,0,1,0,1,0,1,0, 1 (stop). Total 40 cycles low-to-idle, then busy=0.
- Write 0x30 and 0x31 on consecutive cycles → two contiguous 40-cycle frames. No high cycle between frame 1 stop and frame 2 start beyond the stop bit. fifo_count is 0 at the end.
- Write 0x01..0x06 on six consecutive cycles from idle, depth 4 → 0x01 popped after the first write. ready=0 after the fifth write, the sixth write is dropped and overflow=1. Frames 0x01..0x05 are transmitted; 0x06 is never sent.
- Assert reset at cycle 15 of a frame → UART_TX=1 in the same cycle, fifo_count=0, overflow=0, busy=0. No further frames are sent.
- STOP_BITS=2, CLKS_PER_BIT=4, write 0xA3 then 0x00 back-to-back → each frame is 44 cycles, with the stop level held high for 8 cycles before the second start.
- Hold write_enable=1 continuously with changing data_in → the accepted byte count equals the popped count plus 4. No byte is lost while ready=1. The serialised values match data_in sampled at each accepting edge.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular byte FIFO feeding a
// start/data/stop serialiser that runs at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int STOP_BITS       = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     write_enable,
    output logic                     ready,
    output logic                     UART_TX,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    // Timer must also cover the two-bit-long stop period.
    localparam int TW    = $clog2(2 * CLKS_PER_BIT);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_ZERO  = TW'(0);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic [7:0]      mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;

    logic            ready_s;
    logic            push_s;
    logic            pop_s;
    logic            bit_done_s;
    logic            stop_done_s;

    // Handshake and pop decode from registered state.
    always_comb begin
        ready_s     = (count_r != CNT_FULL);
        push_s      = write_enable && ready_s;
        bit_done_s  = (timer_r == BIT_LAST);
        stop_done_s = (timer_r == STOP_LAST);
        pop_s       = 1'b0;
        if (count_r == CNT_ZERO) begin
            pop_s = 1'b0;
        end else if (state_r == IDLE) begin
            pop_s = 1'b1;
        end else if ((state_r == STOP) && stop_done_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CNT_ONE;
            end
            if (write_enable && !ready_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Serialiser FSM; the line level is registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            timer_r   <= TMR_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        timer_r <= TMR_ZERO;
                        state_r <= START;
                        tx_r    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        timer_r   <= TMR_ZERO;
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                        tx_r      <= shift_r[0];
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        timer_r <= TMR_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                STOP: begin
                    if (stop_done_s) begin
                        timer_r <= TMR_ZERO;
                        // Queued data starts the next frame with no idle gap.
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            state_r <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= TMR_ZERO;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = ready_s;
    assign UART_TX    = tx_r;
    assign busy       = (state_r != IDLE) || (count_r != CNT_ZERO);
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule
